data_job_dispatcher: RTL and testbench



---
 rtl/data_path_pkg.sv | 32 +++
 rtl/job_fifo.sv | 79 +++++++
 rtl/data_job_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_data_job_dispatcher.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// -----------------------------------------------------------------------------
// data_path_pkg
//   Types and constants shared by the job dispatcher and data_worker.
//   - AHB_ADDR_WIDTH / PAYLOAD_SIZE_BITS : default address/payload widths.
//   - dispatch_state_t                   : dispatcher FSM states.
//   - job_desc_t                         : queued job descriptor {write, addr, wdata}.
//   - job_level_w()                      : width of a 0..depth occupancy count.
// -----------------------------------------------------------------------------
package data_path_pkg;

   localparam int unsigned AHB_ADDR_WIDTH    = 32;
   localparam int unsigned PAYLOAD_SIZE_BITS = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      FAULT = 2'd3
   } dispatch_state_t;

   typedef struct packed {
      logic                         write;
      logic [AHB_ADDR_WIDTH-1:0]    addr;
      logic [PAYLOAD_SIZE_BITS-1:0] wdata;
   } job_desc_t;

   // Occupancy of a power-of-two queue needs one bit more than its index.
   function automatic int unsigned job_level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/job_fifo.sv
// -----------------------------------------------------------------------------
// job_fifo
//   Synchronous FIFO of job descriptors with an occupancy output.
//   Pointers carry one extra wrap bit: full when the wrap bits differ and the
//   index bits match, empty when the pointers are equal.
//   A push while full is dropped, even if a pop happens in the same cycle.
// Ports
//   clk, rst      : clock, synchronous active-high reset (empties the queue)
//   push_i        : write push_data_i when not full
//   push_data_i   : descriptor to enqueue
//   pop_i         : drop the head entry when not empty
//   head_o        : current head entry (valid when !empty_o)
//   empty_o       : no entries
//   full_o        : pDEPTH entries held
//   level_o       : number of entries held, 0..pDEPTH
// -----------------------------------------------------------------------------
module job_fifo
   import data_path_pkg::*;
#(
   parameter int unsigned pDEPTH  = 4,
   parameter type         pDATA_T = job_desc_t
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_i,
   input  pDATA_T                      push_data_i,
   input  logic                        pop_i,
   output pDATA_T                      head_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [job_level_w(pDEPTH)-1:0] level_o
);

   localparam int unsigned AW = $clog2(pDEPTH);

   pDATA_T      mem_q [pDEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push;
   logic        do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/data_job_dispatcher.sv
// -----------------------------------------------------------------------------
// data_job_dispatcher
//   Upstream job stage for data_worker. Queues read/write job descriptors from
//   a valid/ready producer, issues them one at a time on the go/done port
//   (O_go held until I_done), and returns one in-order response per job.
//   A job that keeps O_go high for pTIMEOUT_CYCLES cycles without I_done is
//   aborted with a timeout response and sets the sticky O_fault; after that
//   response is taken nothing more is issued until rst.
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   I_req_valid / O_req_ready     : producer handshake (ready = queue not full)
//   I_req_write/addr/wdata        : job descriptor
//   O_rsp_valid / I_rsp_ready     : response handshake
//   O_rsp_write/rdata/timeout/error : response payload
//   O_go, O_int_write/addr/wdata  : job issue to data_worker
//   I_done, I_int_rdata(_valid)   : completion from data_worker
//   O_fault                       : sticky timeout flag
//   O_queue_level                 : queued jobs, excluding the in-flight one
// -----------------------------------------------------------------------------
module data_job_dispatcher
   import data_path_pkg::*;
#(
   parameter int unsigned pAHB_ADDR_WIDTH    = AHB_ADDR_WIDTH,
   parameter int unsigned pPAYLOAD_SIZE_BITS = PAYLOAD_SIZE_BITS,
   parameter int unsigned pQUEUE_DEPTH       = 4,
   parameter int unsigned pTIMEOUT_CYCLES    = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   // producer
   input  logic                              I_req_valid,
   output logic                              O_req_ready,
   input  logic                              I_req_write,
   input  logic [pAHB_ADDR_WIDTH-1:0]        I_req_addr,
   input  logic [pPAYLOAD_SIZE_BITS-1:0]     I_req_wdata,
   // consumer
   output logic                              O_rsp_valid,
   input  logic                              I_rsp_ready,
   output logic                              O_rsp_write,
   output logic [pPAYLOAD_SIZE_BITS-1:0]     O_rsp_rdata,
   output logic                              O_rsp_timeout,
   output logic                              O_rsp_error,
   // data_worker
   output logic                              O_go,
   output logic                              O_int_write,
   output logic [pAHB_ADDR_WIDTH-1:0]        O_int_addr,
   output logic [pPAYLOAD_SIZE_BITS-1:0]     O_int_wdata,
   input  logic                              I_done,
   input  logic [pPAYLOAD_SIZE_BITS-1:0]     I_int_rdata,
   input  logic                              I_int_rdata_valid,
   // status
   output logic                              O_fault,
   output logic [$clog2(pQUEUE_DEPTH):0]     O_queue_level
);

   localparam int unsigned TW = $clog2(pTIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(pTIMEOUT_CYCLES - 1);

   // Descriptor sized by this instance's parameters rather than the package defaults.
   typedef struct packed {
      logic                          write;
      logic [pAHB_ADDR_WIDTH-1:0]    addr;
      logic [pPAYLOAD_SIZE_BITS-1:0] wdata;
   } job_t;

   dispatch_state_t state_q;
   logic [TW-1:0]   timer_q;

   logic                          go_q;
   logic                          int_write_q;
   logic [pAHB_ADDR_WIDTH-1:0]    int_addr_q;
   logic [pPAYLOAD_SIZE_BITS-1:0] int_wdata_q;

   logic                          rsp_valid_q;
   logic                          rsp_write_q;
   logic [pPAYLOAD_SIZE_BITS-1:0] rsp_rdata_q;
   logic                          rsp_timeout_q;
   logic                          rsp_error_q;
   logic                          fault_q;

   job_t                          req_job;
   job_t                          head_job;
   logic                          fifo_empty;
   logic                          fifo_full;
   logic                          fifo_pop;

   assign req_job  = '{write: I_req_write, addr: I_req_addr, wdata: I_req_wdata};
   // Must match the IDLE branch of the FSM: the head is consumed exactly when
   // it is copied into the O_int_* registers.
   assign fifo_pop = (state_q == IDLE) && !fifo_empty;

   job_fifo #(
      .pDEPTH  (pQUEUE_DEPTH),
      .pDATA_T (job_t)
   ) u_job_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (I_req_valid),
      .push_data_i (req_job),
      .pop_i       (fifo_pop),
      .head_o      (head_job),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .level_o     (O_queue_level)
   );

   assign O_req_ready = !fifo_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         go_q          <= 1'b0;
         int_write_q   <= 1'b0;
         int_addr_q    <= '0;
         int_wdata_q   <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_error_q   <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  go_q        <= 1'b1;
                  int_write_q <= head_job.write;
                  int_addr_q  <= head_job.addr;
                  int_wdata_q <= head_job.wdata;
                  timer_q     <= '0;
                  state_q     <= ISSUE;
               end
            end

            ISSUE: begin
               // A completion in the last allowed cycle beats the timeout.
               if (I_done) begin
                  go_q          <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_write_q   <= int_write_q;
                  rsp_rdata_q   <= int_write_q ? '0 : I_int_rdata;
                  rsp_timeout_q <= 1'b0;
                  rsp_error_q   <= !int_write_q && !I_int_rdata_valid;
                  state_q       <= RESP;
               end else if (timer_q == TIMER_LAST) begin
                  go_q          <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_write_q   <= int_write_q;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b1;
                  rsp_error_q   <= 1'b0;
                  fault_q       <= 1'b1;
                  state_q       <= RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            RESP: begin
               if (I_rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_write_q   <= 1'b0;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b0;
                  rsp_error_q   <= 1'b0;
                  state_q       <= fault_q ? FAULT : IDLE;
               end
            end

            FAULT: begin
               // Parked until rst; the queue keeps accepting until full.
               state_q <= FAULT;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign O_go          = go_q;
   assign O_int_write   = int_write_q;
   assign O_int_addr    = int_addr_q;
   assign O_int_wdata   = int_wdata_q;
   assign O_rsp_valid   = rsp_valid_q;
   assign O_rsp_write   = rsp_write_q;
   assign O_rsp_rdata   = rsp_rdata_q;
   assign O_rsp_timeout = rsp_timeout_q;
   assign O_rsp_error   = rsp_error_q;
   assign O_fault       = fault_q;

endmodule

// File: tb/tb_data_job_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_data_job_dispatcher
//   Directed scenarios plus a randomized phase, each cycle compared against a
//   transaction-level model: a queue of accepted jobs, the job in flight and
//   the response owed to the consumer.
// -----------------------------------------------------------------------------
module tb_data_job_dispatcher;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic         write;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } job_t;

   typedef struct packed {
      logic         write;
      logic [127:0] rdata;
      logic         timeout;
      logic         error;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         I_req_valid;
   logic         O_req_ready;
   logic         I_req_write;
   logic [31:0]  I_req_addr;
   logic [127:0] I_req_wdata;
   logic         O_rsp_valid;
   logic         I_rsp_ready;
   logic         O_rsp_write;
   logic [127:0] O_rsp_rdata;
   logic         O_rsp_timeout;
   logic         O_rsp_error;
   logic         O_go;
   logic         O_int_write;
   logic [31:0]  O_int_addr;
   logic [127:0] O_int_wdata;
   logic         I_done;
   logic [127:0] I_int_rdata;
   logic         I_int_rdata_valid;
   logic         O_fault;
   logic [2:0]   O_queue_level;

   always #5 clk = ~clk;

   data_job_dispatcher #(
      .pAHB_ADDR_WIDTH    (32),
      .pPAYLOAD_SIZE_BITS (128),
      .pQUEUE_DEPTH       (DEPTH),
      .pTIMEOUT_CYCLES    (TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .I_req_valid       (I_req_valid),
      .O_req_ready       (O_req_ready),
      .I_req_write       (I_req_write),
      .I_req_addr        (I_req_addr),
      .I_req_wdata       (I_req_wdata),
      .O_rsp_valid       (O_rsp_valid),
      .I_rsp_ready       (I_rsp_ready),
      .O_rsp_write       (O_rsp_write),
      .O_rsp_rdata       (O_rsp_rdata),
      .O_rsp_timeout     (O_rsp_timeout),
      .O_rsp_error       (O_rsp_error),
      .O_go              (O_go),
      .O_int_write       (O_int_write),
      .O_int_addr        (O_int_addr),
      .O_int_wdata       (O_int_wdata),
      .I_done            (I_done),
      .I_int_rdata       (I_int_rdata),
      .I_int_rdata_valid (I_int_rdata_valid),
      .O_fault           (O_fault),
      .O_queue_level     (O_queue_level)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   job_t q[$];
   job_t cur;
   rsp_t exp_rsp;
   bit   busy, pend, fault, prev_free;
   int   hi, prev_qsize, lat, go_samples;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic set_job(input logic w, input logic [31:0] a, input logic [127:0] d);
      I_req_valid = 1'b1;
      I_req_write = w;
      I_req_addr  = a;
      I_req_wdata = d;
   endtask

   // One clock: snapshot what the bench drives, advance, update model, compare.
   task automatic step();
      logic d_rst, d_valid, d_done, d_rv, d_ready;
      logic [127:0] d_rdata;
      job_t d_job;
      d_rst   = rst;
      d_valid = I_req_valid;
      d_job   = '{write: I_req_write, addr: I_req_addr, wdata: I_req_wdata};
      d_done  = I_done;
      d_rdata = I_int_rdata;
      d_rv    = I_int_rdata_valid;
      d_ready = I_rsp_ready;
      @(posedge clk);
      #1;
      if (O_go === 1'b1) go_samples++;
      if (d_rst) begin
         q.delete();
         busy = 0; pend = 0; fault = 0; hi = 0;
      end else begin
         if (pend && d_ready) pend = 0;
         if (busy) begin
            if (d_done) begin
               busy = 0; pend = 1;
               exp_rsp = '{write: cur.write, rdata: (cur.write ? 128'h0 : d_rdata),
                           timeout: 1'b0, error: (!cur.write && !d_rv)};
            end else if (hi == TIMEOUT) begin
               busy = 0; pend = 1; fault = 1;
               exp_rsp = '{write: cur.write, rdata: 128'h0, timeout: 1'b1, error: 1'b0};
            end else begin
               hi++;
            end
         end else if (prev_free && prev_qsize > 0 && !fault) begin
            cur  = q.pop_front();
            busy = 1;
            hi   = 1;
         end
         // capacity is judged on the occupancy before this edge
         if (d_valid && prev_qsize < DEPTH) q.push_back(d_job);
      end
      chk("go", O_go, busy);
      if (busy) begin
         chk("int_write", O_int_write, cur.write);
         chk("int_addr",  O_int_addr,  cur.addr);
         chk("int_wdata", O_int_wdata, cur.wdata);
      end
      chk("rsp_valid", O_rsp_valid, pend);
      if (pend) begin
         chk("rsp_write",   O_rsp_write,   exp_rsp.write);
         chk("rsp_rdata",   O_rsp_rdata,   exp_rsp.rdata);
         chk("rsp_timeout", O_rsp_timeout, exp_rsp.timeout);
         chk("rsp_error",   O_rsp_error,   exp_rsp.error);
      end
      chk("level", O_queue_level, q.size());
      chk("ready", O_req_ready, (q.size() < DEPTH));
      chk("fault", O_fault, fault);
      if (d_rst) begin
         chk("rst_int_write", O_int_write, 0);
         chk("rst_int_addr",  O_int_addr,  0);
         chk("rst_int_wdata", O_int_wdata, 0);
         chk("rst_rsp_write", O_rsp_write, 0);
         chk("rst_rsp_rdata", O_rsp_rdata, 0);
         chk("rst_rsp_to",    O_rsp_timeout, 0);
         chk("rst_rsp_err",   O_rsp_error, 0);
      end
      prev_free  = !busy && !pend;
      prev_qsize = q.size();
   endtask

   // Random producer / worker / consumer for the next cycle.
   task automatic rand_drive(input bit prod_en, input bit cons_en, input bit done_en);
      if (prod_en && $urandom_range(0, 2) == 0)
         set_job(1'($urandom()), $urandom(), rand128());
      else
         I_req_valid = 1'b0;
      I_done            = 1'b0;
      I_int_rdata       = rand128();
      I_int_rdata_valid = ($urandom_range(0, 7) != 0);
      if (busy) begin
         if (done_en && hi >= lat) I_done = 1'b1;
      end else begin
         lat = $urandom_range(1, 20);
         // completions outside an issued job must be ignored
         if (done_en && $urandom_range(0, 9) == 0) I_done = 1'b1;
      end
      I_rsp_ready = cons_en && ($urandom_range(0, 1) == 1);
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (!(q.size() == 0 && !busy && !pend) && n < max_cycles) begin
         rand_drive(1'b0, 1'b1, 1'b1);
         step();
         n++;
      end
      if (n >= max_cycles) chk("drain_bound", 0, 1);
      I_done = 1'b0; I_rsp_ready = 1'b0; I_req_valid = 1'b0;
   endtask

   initial begin : main
      job_t jobs [6];
      int   k, guard;

      rst = 1'b1; I_req_valid = 1'b0; I_req_write = 1'b0; I_req_addr = '0;
      I_req_wdata = '0; I_rsp_ready = 1'b0; I_done = 1'b0; I_int_rdata = '0;
      I_int_rdata_valid = 1'b0;
      busy = 0; pend = 0; fault = 0; hi = 0; prev_free = 1; prev_qsize = 0;
      lat = 1; go_samples = 0;

      // reset: all outputs low except ready
      repeat (10) step();
      rst = 1'b0;

      // T1: single read at 0x08
      set_job(1'b0, 32'h8, 128'h0);
      step();
      I_req_valid = 1'b0;
      step();
      chk("t1_go", O_go, 1);
      chk("t1_addr", O_int_addr, 32'h8);
      chk("t1_write", O_int_write, 0);
      I_done = 1'b1; I_int_rdata_valid = 1'b1;
      I_int_rdata = 128'h31c3001967d4acf1bcb25768708627ae;
      step();
      I_done = 1'b0;
      chk("t1_rsp_valid", O_rsp_valid, 1);
      chk("t1_rsp_rdata", O_rsp_rdata, 128'h31c3001967d4acf1bcb25768708627ae);
      chk("t1_rsp_to", O_rsp_timeout, 0);
      chk("t1_rsp_err", O_rsp_error, 0);
      I_rsp_ready = 1'b1;
      step();
      I_rsp_ready = 1'b0;

      // T2: back-to-back pushes with the worker stalled, W,R,W,R,W then a 6th offer
      for (int i = 0; i < 6; i++)
         jobs[i] = '{write: (i % 2 == 0), addr: 32'h100 + 32'(i * 16), wdata: rand128()};
      k = 0; guard = 0;
      while (k < 5 && guard < 20) begin
         set_job(jobs[k].write, jobs[k].addr, jobs[k].wdata);
         if (q.size() < DEPTH) begin step(); k++; end else step();
         guard++;
      end
      if (k < 5) chk("t2_push_bound", 0, 1);
      chk("t2_ready_full", O_req_ready, 0);
      chk("t2_level_full", O_queue_level, 4);
      set_job(jobs[5].write, jobs[5].addr, jobs[5].wdata);
      repeat (3) step();
      I_req_valid = 1'b0;
      chk("t2_held_off", O_queue_level, 4);

      // T3: complete the in-flight job, then hold the response for 20 cycles
      I_done = 1'b1; I_int_rdata = rand128(); I_int_rdata_valid = 1'b1;
      step();
      I_done = 1'b0;
      I_rsp_ready = 1'b0;
      repeat (20) step();
      chk("t3_go_held", O_go, 0);
      chk("t3_level", O_queue_level, 4);
      chk("t3_rsp_valid", O_rsp_valid, 1);
      drain(2000);

      // T5: read finishing without rdata_valid
      set_job(1'b0, 32'h40, 128'h0);
      step();
      I_req_valid = 1'b0;
      step();
      I_done = 1'b1; I_int_rdata = rand128(); I_int_rdata_valid = 1'b0;
      step();
      I_done = 1'b0;
      chk("t5_error", O_rsp_error, 1);
      chk("t5_timeout", O_rsp_timeout, 0);
      I_rsp_ready = 1'b1;
      step();
      I_rsp_ready = 1'b0;

      // completion in the 64th high cycle beats the timeout
      set_job(1'b1, 32'h80, rand128());
      step();
      I_req_valid = 1'b0;
      guard = 0;
      while (!pend && guard < 100) begin
         I_done = busy && (hi == TIMEOUT);
         I_int_rdata_valid = 1'b1;
         step();
         guard++;
      end
      I_done = 1'b0;
      if (!pend) chk("b64_bound", 0, 1);
      chk("b64_timeout", O_rsp_timeout, 0);
      chk("b64_fault", O_fault, 0);
      I_rsp_ready = 1'b1;
      step();
      I_rsp_ready = 1'b0;

      // randomized traffic
      repeat (800) begin
         rand_drive(1'b1, 1'b1, 1'b1);
         step();
      end
      I_req_valid = 1'b0;
      drain(3000);

      // T4: no completion -> timeout after 64 high cycles, then fault
      go_samples = 0;
      for (int i = 0; i < 3; i++) begin
         set_job(1'($urandom()), $urandom(), rand128());
         step();
      end
      I_req_valid = 1'b0;
      guard = 0;
      while (!pend && guard < 200) begin
         step();
         guard++;
      end
      if (!pend) chk("t4_bound", 0, 1);
      chk("t4_go_cycles", go_samples, 64);
      chk("t4_timeout", O_rsp_timeout, 1);
      chk("t4_rdata", O_rsp_rdata, 0);
      chk("t4_fault", O_fault, 1);
      I_rsp_ready = 1'b1;
      step();
      repeat (40) begin
         rand_drive(1'b1, 1'b1, 1'b0);
         step();
      end
      I_req_valid = 1'b0;
      chk("t4_no_issue", O_go, 0);
      chk("t4_fault_sticky", O_fault, 1);

      // T6: reset while a job is in flight with two queued
      rst = 1'b1; I_rsp_ready = 1'b0; I_done = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_job(1'($urandom()), $urandom(), rand128());
         step();
      end
      I_req_valid = 1'b0;
      chk("t6_pre_go", O_go, 1);
      chk("t6_pre_level", O_queue_level, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_go", O_go, 0);
      chk("t6_level", O_queue_level, 0);
      chk("t6_ready", O_req_ready, 1);
      chk("t6_fault", O_fault, 0);
      chk("t6_rsp_valid", O_rsp_valid, 0);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
